// File: rtl/com_pkg.sv
// Shared definitions for the com test-frame generator.
//   - fixed INFO / DATA header bytes
//   - payload mode codes
//   - FSM state encoding
//   - LFSR seed, tap mask and single-step helper
package com_pkg;

   localparam logic [7:0] INFO_HDR0 = 8'h66;
   localparam logic [7:0] INFO_HDR1 = 8'hBB;
   localparam logic [7:0] DATA_HDR0 = 8'h55;
   localparam logic [7:0] DATA_HDR1 = 8'hAA;
   localparam logic [7:0] DATA_HDR2 = 8'hFF;

   localparam logic [1:0] MODE_INC   = 2'd0;
   localparam logic [1:0] MODE_CONST = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_WALK  = 2'd3;

   localparam logic [7:0] LFSR_SEED = 8'h01;
   // Low-order terms of x^8+x^6+x^5+x^4+1; folded in when x^8 overflows.
   localparam logic [7:0] LFSR_TAPS = 8'h71;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StInfo,
      StGInfo,
      StData,
      StGData,
      StDone
   } state_e;

   // Galois step: multiply by x modulo the generator polynomial.
   function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
      return {s[6:0], 1'b0} ^ (s[7] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/com_lfsr8.sv
// 8-bit Galois LFSR used for the pseudo-random payload.
//   clk, rst_n : clock, asynchronous active-low reset (loads the seed)
//   en_i       : advance one step
//   reseed_i   : reload the seed (wins over en_i)
//   q_o        : current LFSR value
module com_lfsr8
   import com_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       reseed_i,
   output logic [7:0] q_o
);

   logic [7:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else if (reseed_i) begin
         lfsr_q <= LFSR_SEED;
      end else if (en_i) begin
         lfsr_q <= lfsr8_step(lfsr_q);
      end
   end

   assign q_o = lfsr_q;

endmodule

// File: rtl/com_pattern_gen.sv
// Test-frame generator for the com transmit path. Each frame writes one INFO packet and
// then one DATA packet per enabled channel into the tx frame RAM.
//   clk, rst_n     : clock, asynchronous active-low reset
//   fs             : frame start request (level; must drop before the next frame)
//   fd             : high while the finished frame waits for fs to drop
//   abort          : synchronous abort back to the wait state
//   mode           : payload pattern, latched at frame start
//   chan_mask      : channel enables, latched at frame start
//   ram_data_txa/d : RAM write address / data
//   ram_data_txen  : write valid; ram_data_txrdy completes the write on a clock edge
//   frame_seq      : sequence number carried by the next frame
module com_pattern_gen
   import com_pkg::*;
#(
   parameter int unsigned   CHAN_NUM   = 6,
   parameter int unsigned   INFO_NUM   = 16,
   parameter int unsigned   DATA_NUM   = 100,
   parameter int unsigned   AW         = 15,
   parameter logic [AW-1:0] INFO_BASE  = AW'(15'h0100),
   parameter logic [AW-1:0] DAT_BASE   = AW'(15'h1000),
   parameter logic [AW-1:0] DAT_STRIDE = AW'(15'h1200)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fs,
   output logic                fd,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [CHAN_NUM-1:0] chan_mask,
   output logic [AW-1:0]       ram_data_txa,
   output logic [7:0]          ram_data_txd,
   output logic                ram_data_txen,
   input  logic                ram_data_txrdy,
   output logic [7:0]          frame_seq
);

   localparam logic [15:0] InfoLast = 16'(INFO_NUM - 1);
   localparam logic [15:0] DataLast = 16'(DATA_NUM - 1);

   state_e              state_q;
   logic [2:0]          ch_q;
   logic [15:0]         cnt_q;
   logic [1:0]          mode_q;
   logic [CHAN_NUM-1:0] mask_q;
   logic [7:0]          seq_q;
   logic [AW-1:0]       txa_q;
   logic [7:0]          txd_q;
   logic                txen_q;
   logic                fd_q;

   logic [7:0]  lfsr_q;
   logic [7:0]  lfsr_adv;
   logic        lfsr_en;
   logic        lfsr_reseed;
   logic [2:0]  first_ch;
   logic [2:0]  next_ch;
   logic        next_ok;
   logic [15:0] cnt_nxt;
   logic [7:0]  info_nxt;
   logic [7:0]  data_nxt;

   function automatic logic [AW-1:0] info_addr(input logic [15:0] k);
      logic [31:0] a;
      a = 32'(INFO_BASE) + 32'(k);
      return a[AW-1:0];
   endfunction

   function automatic logic [AW-1:0] data_addr(input logic [2:0] c, input logic [15:0] k);
      logic [31:0] a;
      a = 32'(DAT_BASE) + 32'(c) * 32'(DAT_STRIDE) + 32'(k);
      return a[AW-1:0];
   endfunction

   com_lfsr8 u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (lfsr_en),
      .reseed_i (lfsr_reseed),
      .q_o      (lfsr_q)
   );

   assign lfsr_reseed = (state_q == StWait) && fs && !abort;
   assign lfsr_en     = (state_q == StData) && ram_data_txrdy && (cnt_q >= 16'd4) && !abort;

   // Lowest enabled channel of the incoming mask, and next enabled channel above ch_q.
   always_comb begin
      first_ch = 3'd0;
      next_ch  = 3'd0;
      next_ok  = 1'b0;
      for (int i = int'(CHAN_NUM) - 1; i >= 0; i--) begin
         if (chan_mask[i]) begin
            first_ch = 3'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            next_ok = 1'b1;
            next_ch = 3'(i);
         end
      end
   end

   // Byte to present after the current one is accepted.
   always_comb begin
      cnt_nxt  = cnt_q + 16'd1;
      // Payload acceptance advances the LFSR, so the following byte sees its successor.
      lfsr_adv = (cnt_q >= 16'd4) ? lfsr8_step(lfsr_q) : lfsr_q;

      info_nxt = 8'(cnt_nxt) + 8'h10;
      case (cnt_nxt)
         16'd0:   info_nxt = INFO_HDR0;
         16'd1:   info_nxt = INFO_HDR1;
         16'd2:   info_nxt = seq_q;
         16'd3:   info_nxt = 8'(mask_q);
         default: ;
      endcase

      data_nxt = DATA_HDR0;
      case (cnt_nxt)
         16'd0: data_nxt = DATA_HDR0;
         16'd1: data_nxt = DATA_HDR1;
         16'd2: data_nxt = DATA_HDR2;
         16'd3: data_nxt = {5'd0, ch_q} + 8'd1;
         default: begin
            unique case (mode_q)
               MODE_INC:   data_nxt = 8'(cnt_nxt) + 8'h20 + {1'b0, ch_q, 4'h0};
               MODE_CONST: data_nxt = 8'hA5;
               MODE_LFSR:  data_nxt = lfsr_adv;
               MODE_WALK:  data_nxt = 8'h01 << (cnt_nxt[2:0] - 3'd4);
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ch_q    <= 3'd0;
         cnt_q   <= 16'd0;
         mode_q  <= MODE_INC;
         mask_q  <= '0;
         seq_q   <= 8'd0;
         txa_q   <= '0;
         txd_q   <= 8'd0;
         txen_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else if (abort && (state_q != StIdle)) begin
         // Frame is dropped as-is; RAM keeps whatever was already written.
         state_q <= StWait;
         txen_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StWait;

            StWait: begin
               fd_q <= 1'b0;
               if (fs) begin
                  state_q <= StInfo;
                  mode_q  <= mode;
                  mask_q  <= chan_mask;
                  ch_q    <= first_ch;
                  cnt_q   <= 16'd0;
                  txen_q  <= 1'b1;
                  txa_q   <= info_addr(16'd0);
                  txd_q   <= INFO_HDR0;
               end
            end

            StInfo: begin
               if (ram_data_txrdy) begin
                  if (cnt_q == InfoLast) begin
                     state_q <= StGInfo;
                     txen_q  <= 1'b0;
                     cnt_q   <= 16'd0;
                  end else begin
                     cnt_q <= cnt_nxt;
                     txa_q <= info_addr(cnt_nxt);
                     txd_q <= info_nxt;
                  end
               end
            end

            StGInfo: begin
               if (mask_q != '0) begin
                  state_q <= StData;
                  txen_q  <= 1'b1;
                  txa_q   <= data_addr(ch_q, 16'd0);
                  txd_q   <= DATA_HDR0;
               end else begin
                  state_q <= StDone;
                  fd_q    <= 1'b1;
                  seq_q   <= seq_q + 8'd1;
               end
            end

            StData: begin
               if (ram_data_txrdy) begin
                  if (cnt_q == DataLast) begin
                     state_q <= StGData;
                     txen_q  <= 1'b0;
                     cnt_q   <= 16'd0;
                  end else begin
                     cnt_q <= cnt_nxt;
                     txa_q <= data_addr(ch_q, cnt_nxt);
                     txd_q <= data_nxt;
                  end
               end
            end

            StGData: begin
               if (next_ok) begin
                  state_q <= StData;
                  ch_q    <= next_ch;
                  txen_q  <= 1'b1;
                  txa_q   <= data_addr(next_ch, 16'd0);
                  txd_q   <= DATA_HDR0;
               end else begin
                  state_q <= StDone;
                  fd_q    <= 1'b1;
                  seq_q   <= seq_q + 8'd1;
               end
            end

            StDone: begin
               // A frame only restarts after fs has been seen low.
               if (!fs) begin
                  state_q <= StWait;
                  fd_q    <= 1'b0;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign fd            = fd_q;
   assign ram_data_txa  = txa_q;
   assign ram_data_txd  = txd_q;
   assign ram_data_txen = txen_q;
   assign frame_seq     = seq_q;

endmodule

// File: tb/tb_com_pattern_gen.sv
module tb_com_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fs = 1'b0;
   logic        abort = 1'b0;
   logic        txrdy = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [5:0]  chan_mask = 6'd0;
   logic        fd;
   logic [14:0] txa;
   logic [7:0]  txd;
   logic        txen;
   logic [7:0]  frame_seq;

   always #5 clk = ~clk;

   com_pattern_gen dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fs             (fs),
      .fd             (fd),
      .abort          (abort),
      .mode           (mode),
      .chan_mask      (chan_mask),
      .ram_data_txa   (txa),
      .ram_data_txd   (txd),
      .ram_data_txen  (txen),
      .ram_data_txrdy (txrdy),
      .frame_seq      (frame_seq)
   );

   typedef struct packed {
      logic [14:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] ram[int];
   int         n_checks = 0;
   int         n_fail = 0;
   int         exp_seq = 0;
   int         last_addr = -1;
   int         dur;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rd(input int a);
      return ram.exists(a) ? int'(ram[a]) : -1;
   endfunction

   // Multiply by x in GF(2)[x] modulo x^8+x^6+x^5+x^4+1.
   function automatic logic [7:0] gf_mul_x(input logic [7:0] s);
      int v;
      v = int'(s) * 2;
      if (v >= 256) v = v ^ 'h171;
      return 8'(v);
   endfunction

   // Reference model: full list of writes a frame should produce, in order.
   task automatic build_frame(input logic [5:0] m, input logic [1:0] md, input int seq);
      wr_t        w;
      logic [7:0] lf;
      int         d;
      for (int k = 0; k < 16; k++) begin
         case (k)
            0:       d = 'h66;
            1:       d = 'hBB;
            2:       d = seq;
            3:       d = int'(m);
            default: d = (k + 'h10) % 256;
         endcase
         w.a = 15'('h100 + k);
         w.d = 8'(d);
         exp_q.push_back(w);
      end
      lf = 8'h01;
      for (int c = 0; c < 6; c++) begin
         if (m[c]) begin
            for (int k = 0; k < 100; k++) begin
               if (k == 0) d = 'h55;
               else if (k == 1) d = 'hAA;
               else if (k == 2) d = 'hFF;
               else if (k == 3) d = c + 1;
               else begin
                  case (md)
                     2'd0: d = (k + 'h20 + 'h10 * c) % 256;
                     2'd1: d = 'hA5;
                     2'd2: begin
                        d  = int'(lf);
                        lf = gf_mul_x(lf);
                     end
                     default: d = 1 << ((k - 4) % 8);
                  endcase
               end
               w.a = 15'(('h1000 + c * 'h1200 + k) % 32768);
               w.d = 8'(d);
               exp_q.push_back(w);
            end
         end
      end
   endtask

   // Monitor: a write completes on the next rising edge when txen && txrdy and no abort.
   always @(negedge clk) begin
      if (rst_n && txen && txrdy && !abort) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", txa, txd);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", int'(txa), int'(e.a));
            chk("wr_data", int'(txd), int'(e.d));
         end
         ram[int'(txa)] = txd;
         last_addr = int'(txa);
      end
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_txen"}, int'(txen), 0);
      chk({tag, "_fd"}, int'(fd), 0);
      chk({tag, "_txa"}, int'(txa), 0);
      chk({tag, "_txd"}, int'(txd), 0);
      chk({tag, "_seq"}, int'(frame_seq), 0);
   endtask

   // Runs one frame; dur = cycles from the first INFO cycle to fd.
   task automatic run_frame(input logic [5:0] m, input logic [1:0] md, input bit rnd,
                            input bit keep_fs, input int hold_at, input int hold_txd,
                            input int abort_at, output int dur_o);
      int first, hold_left, result;
      bit hold_done;
      first = -1; hold_left = 0; hold_done = 0; result = 0; dur_o = -1;
      build_frame(m, md, exp_seq);
      fs = 1'b1; mode = md; chan_mask = m;
      txrdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int cyc = 0; cyc < 4000 && result == 0; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 0) begin
            if (!keep_fs) fs = 1'b0;
            // Mid-frame changes must not matter: both are latched at frame start.
            mode = 2'($urandom);
            chan_mask = 6'($urandom);
         end
         if (txen && first < 0) begin
            first = cyc;
            chk("first_info_addr", int'(txa), 'h100);
         end
         if (fd) begin
            dur_o = cyc - first;
            result = 1;
         end else if (abort_at >= 0 && txen && int'(txa) == abort_at) begin
            if (exp_q.size() > 0) chk("abort_q_front", int'(exp_q[0].a), abort_at);
            else chk("abort_q_front", -1, abort_at);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_txen", int'(txen), 0);
            chk("abort_seq", int'(frame_seq), exp_seq);
            exp_q.delete();
            result = 2;
         end else begin
            if (hold_left > 0) begin
               chk("hold_txa", int'(txa), hold_at);
               chk("hold_txd", int'(txd), hold_txd);
               hold_left--;
            end else if (hold_at >= 0 && !hold_done && txen && int'(txa) == hold_at) begin
               chk("hold_txd", int'(txd), hold_txd);
               hold_left = 5;
               hold_done = 1;
            end
            txrdy = (hold_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         end
      end
      if (result == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_timeout: fd not seen, expected fd within 4000 cycles");
         exp_q.delete();
      end else if (result == 1) begin
         exp_seq = (exp_seq + 1) % 256;
         chk("queue_drained", exp_q.size(), 0);
         chk("frame_seq", int'(frame_seq), exp_seq);
         if (keep_fs) begin
            repeat (4) begin
               @(posedge clk); #1;
               chk("fs_held_fd", int'(fd), 1);
               chk("fs_held_txen", int'(txen), 0);
            end
         end
      end
      fs = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("idle_fd", int'(fd), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // All channels, incrementing payload, full-rate handshake, fs held past DONE.
      ram.delete(); last_addr = -1;
      run_frame(6'h3F, 2'd0, 1'b0, 1'b1, -1, 0, -1, dur);
      chk("frame_cycles", dur, 623);
      chk("ram_0100", rd('h0100), 'h66);
      chk("ram_0104", rd('h0104), 'h14);
      chk("ram_2200", rd('h2200), 'h55);
      chk("ram_2203", rd('h2203), 'h02);
      chk("ram_2204", rd('h2204), 'h34);
      chk("last_addr", last_addr, 'h6A63);
      chk("seq_after_first", int'(frame_seq), 1);

      // Sparse mask, constant payload, random backpressure.
      ram.delete();
      run_frame(6'b100101, 2'd1, 1'b1, 1'b0, -1, 0, -1, dur);
      chk("ram_6A04", rd('h6A04), 'hA5);
      chk("ram_2200_unwritten", rd('h2200), -1);
      chk("ram_4600_unwritten", rd('h4600), -1);
      chk("info_mask_byte", rd('h0103), 'h25);

      // LFSR payload twice: must restart from the seed each frame.
      for (int r = 0; r < 2; r++) begin
         ram.delete();
         run_frame(6'h01, 2'd2, 1'b1, 1'b0, -1, 0, -1, dur);
         chk("lfsr_first", rd('h1004), 'h01);
         chk("lfsr_second", rd('h1005), 'h02);
         chk("lfsr_ninth", rd('h100C), 'h71);
      end

      // Five-cycle stall at channel 1 byte 10.
      run_frame(6'h3F, 2'd0, 1'b0, 1'b0, 'h220A, 'h3A, -1, dur);
      chk("stall_frame_cycles", dur, 628);

      // Abort inside channel 3, then a fresh frame.
      run_frame(6'h3F, 2'd0, 1'b0, 1'b0, -1, 0, 'h4610, dur);
      run_frame(6'h01, 2'd3, 1'b1, 1'b0, -1, 0, -1, dur);

      // Asynchronous reset in the middle of DATA.
      build_frame(6'h3F, 2'd3, exp_seq);
      fs = 1'b1; mode = 2'd3; chan_mask = 6'h3F; txrdy = 1'b1;
      begin
         bit seen;
         seen = 0;
         for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            @(posedge clk); #1;
            fs = 1'b0;
            if (txen && txa == 15'h1030) seen = 1;
         end
         if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL reset_target_timeout: addr 0x1030 not presented, expected within 2000 cycles");
         end
      end
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      exp_q.delete();
      exp_seq = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Empty mask: INFO only, straight to DONE.
      ram.delete();
      run_frame(6'h00, 2'd0, 1'b0, 1'b0, -1, 0, -1, dur);
      chk("empty_mask_cycles", dur, 17);
      chk("empty_mask_writes", ram.size(), 16);
      chk("empty_mask_no_data", rd('h1000), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
